// File: rtl/pio_loopback_sequencer_pkg.sv
// Shared types and constants for the PIO loopback self-test blocks.
// Imported by the sequencer and the input synchroniser.
package pio_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } pio_seq_state_t;

    localparam int PIO_SYNC_STAGES = 2;

endpackage

// File: rtl/pio_loopback_sequencer_in_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous PIO input data.
// Each bit is synchronised independently, so there is no cross-bit coherence.
module pio_in_sync
    import pio_test_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_stages [PIO_SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < PIO_SYNC_STAGES; s++) begin
                r_stages[s] <= '0;
            end
        end else begin
            r_stages[0] <= i_async;
            for (int s = 1; s < PIO_SYNC_STAGES; s++) begin
                r_stages[s] <= r_stages[s-1];
            end
        end
    end

    assign o_sync = r_stages[PIO_SYNC_STAGES-1];

endmodule

// File: rtl/pio_loopback_sequencer.sv
// Walks every PIO in turn, drives 0 then 1 onto it, and checks the synchronised readback.
// Per-pin failures accumulate in fail_mask. pass summarises a sweep that completes normally.
module pio_loopback_sequencer
    import pio_test_pkg::*;
#(
    parameter int NUM_IO        = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [NUM_IO-1:0] io_t,
    output logic [NUM_IO-1:0] io_o,
    input  logic [NUM_IO-1:0] io_i,
    output logic              busy,
    output logic              done,
    output logic [NUM_IO-1:0] fail_mask,
    output logic              pass
);

    localparam int IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_PIN = IDX_W'(NUM_IO - 1);

    pio_seq_state_t    r_state;
    pio_seq_state_t    w_next;
    logic [IDX_W-1:0]  r_pin;
    logic              r_phase;
    logic [CNT_W-1:0]  r_cnt;
    logic [NUM_IO-1:0] r_fail;
    logic              r_pass;
    logic [NUM_IO-1:0] w_sync;
    logic              w_last_pin;
    logic              w_accept;

    pio_in_sync #(
        .WIDTH (NUM_IO)
    ) u_in_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (io_i),
        .o_sync  (w_sync)
    );

    assign w_last_pin = (r_pin == LAST_PIN);
    // If start and abort arrive together, abort wins and the start is dropped.
    assign w_accept   = start & ~abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (r_cnt == '0) begin
                    w_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (r_phase && w_last_pin) begin
                    w_next = DONE;
                end else begin
                    w_next = SETTLE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // fail bits are sticky within a sweep. Only an accepted start or reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pin   <= '0;
            r_phase <= 1'b0;
            r_cnt   <= '0;
            r_fail  <= '0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pin   <= '0;
                        r_phase <= 1'b0;
                        r_cnt   <= CNT_LOAD;
                        r_fail  <= '0;
                        r_pass  <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (!abort && r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (!abort) begin
                        if (w_sync[r_pin] != r_phase) begin
                            r_fail[r_pin] <= 1'b1;
                        end
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            r_cnt   <= CNT_LOAD;
                        end else if (!w_last_pin) begin
                            r_pin   <= r_pin + IDX_W'(1);
                            r_phase <= 1'b0;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                DONE: begin
                    r_pass <= ~|r_fail;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        io_t = '1;
        io_o = '0;
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            SETTLE, SAMPLE: begin
                io_t[r_pin] = 1'b0;
                io_o[r_pin] = r_phase;
                busy        = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign fail_mask = r_fail;
    assign pass      = r_pass;

endmodule

// File: tb/tb_pio_loopback_sequencer.sv
// Directed bench for pio_loopback_sequencer with NUM_IO=4 and SETTLE_CYCLES=4.
// io_i is a loopback model with per-pin stuck-at-0, stuck-at-1 and inversion faults.
module tb_pio_loopback_sequencer;

    localparam int NUM_IO = 4;
    localparam int SETTLE = 4;
    localparam int LATENCY = NUM_IO * 2 * (SETTLE + 1) + 1;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic abort;
    logic [NUM_IO-1:0] io_t;
    logic [NUM_IO-1:0] io_o;
    logic [NUM_IO-1:0] io_i;
    logic busy;
    logic done;
    logic [NUM_IO-1:0] fail_mask;
    logic pass;

    logic [NUM_IO-1:0] stuck0;
    logic [NUM_IO-1:0] stuck1;
    logic [NUM_IO-1:0] inv;

    int checks;
    int failures;
    int cyc;

    assign io_i = ((((~io_t) & io_o) & ~stuck0) | stuck1) ^ inv;

    always #5 clk = ~clk;

    pio_loopback_sequencer #(
        .NUM_IO        (NUM_IO),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .io_t      (io_t),
        .io_o      (io_o),
        .io_i      (io_i),
        .busy      (busy),
        .done      (done),
        .fail_mask (fail_mask),
        .pass      (pass)
    );

    // The cycle counter counts observation points at the falling edge. The start cycle is cycle 0.
    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic begin_sweep();
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        while (!done && cyc < 200) tick();
        dcyc = done ? cyc : -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (io_t !== 4'b1111 || io_o !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 ||
            fail_mask !== 4'b0000 || pass !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: io_t=%b io_o=%b busy=%b done=%b fail_mask=%b pass=%b",
                     io_t, io_o, busy, done, fail_mask, pass);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback_good();
        logic [NUM_IO-1:0] exp_t;
        logic [NUM_IO-1:0] exp_o;
        int pin;
        int ph;
        stuck0 = '0; stuck1 = '0; inv = '0;
        begin_sweep();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_rise: busy=%b expected 1", busy);
        end
        for (int c = 1; c < LATENCY; c++) begin
            pin   = (c - 1) / 10;
            ph    = ((c - 1) % 10) / 5;
            exp_t = 4'b1111 ^ (4'b0001 << pin);
            exp_o = (ph == 1) ? (4'b0001 << pin) : 4'b0000;
            checks++;
            if (io_t !== exp_t || io_o !== exp_o) begin
                failures++;
                $display("[TB] FAIL drive_order c=%0d: io_t=%b io_o=%b expected %b %b",
                         c, io_t, io_o, exp_t, exp_o);
            end
            checks++;
            if ($countones(~io_t) > 1 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL exclusivity c=%0d: io_t=%b done=%b", c, io_t, done);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || io_t !== 4'b1111 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL done_cycle: done=%b io_t=%b busy=%b at cycle %0d expected 1 1111 1",
                     done, io_t, busy, cyc);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || io_t !== 4'b1111 || fail_mask !== 4'b0000 || pass !== 1'b1) begin
            failures++;
            $display("[TB] FAIL good_result: done=%b busy=%b io_t=%b fail_mask=%b pass=%b expected 0 0 1111 0000 1",
                     done, busy, io_t, fail_mask, pass);
        end
    endtask

    task automatic test_stuck_at_0();
        int dcyc;
        stuck0 = 4'b0100; stuck1 = '0; inv = '0;
        begin_sweep();
        while (cyc < 28) tick();
        checks++;
        if (fail_mask[2] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stuck0_phase0: fail_mask[2]=%b expected 0", fail_mask[2]);
        end
        while (cyc < 32) tick();
        checks++;
        if (fail_mask[2] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stuck0_phase1: fail_mask[2]=%b expected 1", fail_mask[2]);
        end
        wait_done(dcyc);
        checks++;
        if (dcyc !== LATENCY) begin
            failures++;
            $display("[TB] FAIL stuck0_latency: done at %0d expected %0d", dcyc, LATENCY);
        end
        tick();
        checks++;
        if (fail_mask !== 4'b0100 || pass !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stuck0_result: fail_mask=%b pass=%b expected 0100 0", fail_mask, pass);
        end
    endtask

    task automatic test_stuck_and_invert();
        int dcyc;
        stuck0 = '0; stuck1 = 4'b0001; inv = 4'b1000;
        begin_sweep();
        wait_done(dcyc);
        checks++;
        if (dcyc !== LATENCY) begin
            failures++;
            $display("[TB] FAIL multi_latency: done at %0d expected %0d", dcyc, LATENCY);
        end
        tick();
        checks++;
        if (fail_mask !== 4'b1001 || pass !== 1'b0) begin
            failures++;
            $display("[TB] FAIL multi_result: fail_mask=%b pass=%b expected 1001 0", fail_mask, pass);
        end
        stuck1 = '0; inv = '0;
    endtask

    task automatic test_abort();
        int dcyc;
        int seen;
        begin_sweep();
        while (cyc < 15) tick();
        checks++;
        if (io_t !== 4'b1101 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_pre: io_t=%b busy=%b expected 1101 1", io_t, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (io_t !== 4'b1111 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_idle: io_t=%b busy=%b done=%b expected 1111 0 0", io_t, busy, done);
        end
        seen = 0;
        repeat (50) begin
            tick();
            if (done) seen = 1;
        end
        checks++;
        if (seen !== 0 || pass !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_no_done: done_seen=%0d pass=%b expected 0 0", seen, pass);
        end
        begin_sweep();
        wait_done(dcyc);
        checks++;
        if (dcyc !== LATENCY) begin
            failures++;
            $display("[TB] FAIL restart_latency: done at %0d expected %0d", dcyc, LATENCY);
        end
        tick();
        checks++;
        if (pass !== 1'b1 || fail_mask !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL restart_result: pass=%b fail_mask=%b expected 1 0000", pass, fail_mask);
        end
    endtask

    task automatic test_async_reset();
        stuck0 = 4'b0001;
        begin_sweep();
        while (cyc < 12) tick();
        checks++;
        if (fail_mask !== 4'b0001 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pre_reset: fail_mask=%b busy=%b expected 0001 1", fail_mask, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (io_t !== 4'b1111 || io_o !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 ||
            pass !== 1'b0 || fail_mask !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL async_reset: io_t=%b io_o=%b busy=%b done=%b pass=%b fail_mask=%b",
                     io_t, io_o, busy, done, pass, fail_mask);
        end
        @(negedge clk);
        rst = 1'b0;
        stuck0 = '0;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int dcyc;
        begin_sweep();
        while (cyc < 5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(dcyc);
        checks++;
        if (dcyc !== LATENCY) begin
            failures++;
            $display("[TB] FAIL busy_start_ignored: done at %0d expected %0d", dcyc, LATENCY);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || pass !== 1'b1 || io_t !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL done_start_ignored: busy=%b pass=%b io_t=%b expected 0 1 1111",
                     busy, pass, io_t);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        stuck0 = '0; stuck1 = '0; inv = '0;
        checks = 0; failures = 0; cyc = 0;
        test_reset();
        test_loopback_good();
        test_stuck_at_0();
        test_stuck_and_invert();
        test_abort();
        test_async_reset();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
